entity_motion_engine: RTL and testbench



---
 rtl/asteroids_pkg.sv | 34 +++
 rtl/axis_wrap_step.sv | 47 ++++
 rtl/entity_motion_engine.sv | 180 ++++++++++++++++++
 tb/tb_entity_motion_engine.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asteroids_pkg.sv
// Shared definitions for the asteroids motion datapath.
//   - command opcodes carried on cmd_op
//   - default screen size and fixed-point format
//   - per-slot entity record at the default geometry
//   - sweep FSM state encoding
package asteroids_pkg;

  localparam logic [1:0] OP_SPAWN = 2'b00;
  localparam logic [1:0] OP_KILL  = 2'b01;
  localparam logic [1:0] OP_SETV  = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b11;

  localparam int SCREEN_X_MAX = 320;
  localparam int SCREEN_Y_MAX = 240;

  localparam int FRAC_DEF = 4;
  localparam int XW_DEF   = 10;
  localparam int YW_DEF   = 10;
  localparam int VW_DEF   = 8;

  typedef struct packed {
    logic                     active;
    logic [XW_DEF+FRAC_DEF-1:0] x_fx;
    logic [YW_DEF+FRAC_DEF-1:0] y_fx;
    logic signed [VW_DEF-1:0] vx;
    logic signed [VW_DEF-1:0] vy;
  } entity_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_t;

endpackage

// File: rtl/axis_wrap_step.sv
// One axis of a slot update: fixed-point position plus signed velocity, with
// either toroidal wrap or out-of-range detection.
//   p_in         current position, unsigned fixed point (W integer, FRAC fraction)
//   v_in         signed velocity in sub-pixel units
//   p_out        next position (wrapped when WRAP=1, raw sum otherwise)
//   out_of_range raw sum fell outside [0, LIMIT<<FRAC)
module axis_wrap_step
  import asteroids_pkg::*;
#(
  parameter int W     = 10,
  parameter int FRAC  = 4,
  parameter int VW    = 8,
  parameter int LIMIT = 320,
  parameter int WRAP  = 1
) (
  input  logic [W+FRAC-1:0]    p_in,
  input  logic signed [VW-1:0] v_in,
  output logic [W+FRAC-1:0]    p_out,
  output logic                 out_of_range
);

  localparam int PW = W + FRAC;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] LIM = SW'(LIMIT << FRAC);

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] res;
  logic                 unused_res_msb;

  always_comb begin
    sum          = $signed({1'b0, p_in}) + $signed({{(SW-VW){v_in[VW-1]}}, v_in});
    out_of_range = (sum < 0) || (sum >= LIM);
    res          = sum;
    // |v| < LIM, so one correction always lands back in range.
    if (WRAP != 0) begin
      if (sum < 0) begin
        res = sum + LIM;
      end else if (sum >= LIM) begin
        res = sum - LIM;
      end
    end
  end

  assign p_out          = res[PW-1:0];
  assign unused_res_msb = res[SW-1];

endmodule

// File: rtl/entity_motion_engine.sv
// Motion engine for N_ENT game entity slots. Each slot holds a fixed-point
// position and signed velocity; a sweep advances every active slot once, one
// slot per move_clk cycle. Commands (spawn/kill/set velocity) are accepted
// only while idle.
//   move_clk, reset_n      clock, synchronous active-low reset
//   enable                 request a sweep
//   cmd_valid/cmd_ready    command handshake (ready while idle)
//   cmd_op/slot/x/y/vx/vy  command payload
//   ent_active/ent_x/ent_y flattened per-slot state, slot i at [i*W +: W]
//   sweep_done             pulse after the last slot is updated
//   exit_event/exit_slot   pulse when a slot leaves the screen (WRAP=0)
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | accept commands; start a sweep on enable if no command
// ST_SWEEP | update slot idx each cycle; return to idle after last slot
module entity_motion_engine
  import asteroids_pkg::*;
#(
  parameter int N_ENT = 8,
  parameter int XW    = XW_DEF,
  parameter int YW    = YW_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int VW    = VW_DEF,
  parameter int X_MAX = SCREEN_X_MAX,
  parameter int Y_MAX = SCREEN_Y_MAX,
  parameter int WRAP  = 1
) (
  input  logic                     move_clk,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [$clog2(N_ENT)-1:0] cmd_slot,
  input  logic [XW-1:0]            cmd_x,
  input  logic [YW-1:0]            cmd_y,
  input  logic [VW-1:0]            cmd_vx,
  input  logic [VW-1:0]            cmd_vy,
  output logic [N_ENT-1:0]         ent_active,
  output logic [N_ENT*XW-1:0]      ent_x,
  output logic [N_ENT*YW-1:0]      ent_y,
  output logic                     sweep_done,
  output logic                     exit_event,
  output logic [$clog2(N_ENT)-1:0] exit_slot
);

  localparam int IW  = $clog2(N_ENT);
  localparam int PXW = XW + FRAC;
  localparam int PYW = YW + FRAC;

  sweep_state_t state, state_nx;

  logic [IW-1:0]        idx;
  logic [N_ENT-1:0]     act;
  logic [PXW-1:0]       px [N_ENT];
  logic [PYW-1:0]       py [N_ENT];
  logic signed [VW-1:0] vx [N_ENT];
  logic signed [VW-1:0] vy [N_ENT];

  logic [PXW-1:0] nx;
  logic [PYW-1:0] ny;
  logic           x_exit, y_exit;
  logic           last_slot;
  logic [XW-1:0]  spawn_x;
  logic [YW-1:0]  spawn_y;

  assign last_slot = (idx == IW'(N_ENT - 1));
  assign spawn_x   = (cmd_x > XW'(X_MAX - 1)) ? XW'(X_MAX - 1) : cmd_x;
  assign spawn_y   = (cmd_y > YW'(Y_MAX - 1)) ? YW'(Y_MAX - 1) : cmd_y;

  axis_wrap_step #(
    .W(XW), .FRAC(FRAC), .VW(VW), .LIMIT(X_MAX), .WRAP(WRAP)
  ) u_step_x (
    .p_in(px[idx]), .v_in(vx[idx]), .p_out(nx), .out_of_range(x_exit)
  );

  axis_wrap_step #(
    .W(YW), .FRAC(FRAC), .VW(VW), .LIMIT(Y_MAX), .WRAP(WRAP)
  ) u_step_y (
    .p_in(py[idx]), .v_in(vy[idx]), .p_out(ny), .out_of_range(y_exit)
  );

  always_ff @(posedge move_clk) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // A pending command always wins over enable while idle.
  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (!cmd_valid && enable) begin
          state_nx = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (last_slot) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge move_clk) begin
    if (!reset_n) begin
      idx        <= '0;
      act        <= '0;
      sweep_done <= 1'b0;
      exit_event <= 1'b0;
      exit_slot  <= '0;
      for (int i = 0; i < N_ENT; i++) begin
        px[i] <= '0;
        py[i] <= '0;
        vx[i] <= '0;
        vy[i] <= '0;
      end
    end else begin
      sweep_done <= 1'b0;
      exit_event <= 1'b0;
      if (state == ST_IDLE) begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_SPAWN: begin
              act[cmd_slot] <= 1'b1;
              px[cmd_slot]  <= {spawn_x, {FRAC{1'b0}}};
              py[cmd_slot]  <= {spawn_y, {FRAC{1'b0}}};
              vx[cmd_slot]  <= cmd_vx;
              vy[cmd_slot]  <= cmd_vy;
            end
            OP_KILL: act[cmd_slot] <= 1'b0;
            OP_SETV: begin
              vx[cmd_slot] <= cmd_vx;
              vy[cmd_slot] <= cmd_vy;
            end
            default: ;
          endcase
        end else if (enable) begin
          idx <= '0;
        end
      end else begin
        if (act[idx]) begin
          // Without wrap, an exit on either axis kills the slot in place.
          if ((WRAP == 0) && (x_exit || y_exit)) begin
            act[idx]   <= 1'b0;
            exit_event <= 1'b1;
            exit_slot  <= idx;
          end else begin
            px[idx] <= nx;
            py[idx] <= ny;
          end
        end
        if (last_slot) begin
          idx        <= '0;
          sweep_done <= 1'b1;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  always_comb begin
    ent_active = act;
    ent_x      = '0;
    ent_y      = '0;
    for (int i = 0; i < N_ENT; i++) begin
      ent_x[i*XW +: XW] = px[i][FRAC +: XW];
      ent_y[i*YW +: YW] = py[i][FRAC +: YW];
    end
  end

endmodule

// File: tb/tb_entity_motion_engine.sv
module tb_entity_motion_engine;
  import asteroids_pkg::*;

  localparam int N    = 8;
  localparam int XW   = 10;
  localparam int YW   = 10;
  localparam int FRAC = 4;
  localparam int VW   = 8;
  localparam int LX   = 320 * 16;
  localparam int LY   = 240 * 16;

  logic          move_clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = OP_NOP;
  logic [2:0]    cmd_slot = '0;
  logic [XW-1:0] cmd_x = '0;
  logic [YW-1:0] cmd_y = '0;
  logic [VW-1:0] cmd_vx = '0;
  logic [VW-1:0] cmd_vy = '0;

  logic            w_cmd_ready, k_cmd_ready;
  logic [N-1:0]    w_ent_active, k_ent_active;
  logic [N*XW-1:0] w_ent_x, k_ent_x;
  logic [N*YW-1:0] w_ent_y, k_ent_y;
  logic            w_sweep_done, k_sweep_done;
  logic            w_exit_event, k_exit_event;
  logic [2:0]      w_exit_slot, k_exit_slot;

  entity_motion_engine #(.WRAP(1)) dut_w (
    .move_clk(move_clk), .reset_n(reset_n), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(w_cmd_ready), .cmd_op(cmd_op),
    .cmd_slot(cmd_slot), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .cmd_vx(cmd_vx), .cmd_vy(cmd_vy),
    .ent_active(w_ent_active), .ent_x(w_ent_x), .ent_y(w_ent_y),
    .sweep_done(w_sweep_done), .exit_event(w_exit_event), .exit_slot(w_exit_slot)
  );

  entity_motion_engine #(.WRAP(0)) dut_k (
    .move_clk(move_clk), .reset_n(reset_n), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(k_cmd_ready), .cmd_op(cmd_op),
    .cmd_slot(cmd_slot), .cmd_x(cmd_x), .cmd_y(cmd_y),
    .cmd_vx(cmd_vx), .cmd_vy(cmd_vy),
    .ent_active(k_ent_active), .ent_x(k_ent_x), .ent_y(k_ent_y),
    .sweep_done(k_sweep_done), .exit_event(k_exit_event), .exit_slot(k_exit_slot)
  );

  always #5 move_clk = ~move_clk;

  typedef struct {
    logic [N-1:0]    act;
    logic [N*XW-1:0] x;
    logic [N*YW-1:0] y;
  } exp_t;

  exp_t sb[$];
  exp_t sb_e;

  int n_chk = 0;
  int n_fail = 0;
  int m_x[N], m_y[N], m_vx[N], m_vy[N];
  bit m_act[N];
  int cyc = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int k_exits = 0;
  int k_exit_seen = -1;
  int w_exits = 0;
  int busy = 0;

  task automatic chk_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t snap();
    exp_t r;
    r.act = '0;
    r.x   = '0;
    r.y   = '0;
    for (int i = 0; i < N; i++) begin
      r.act[i]        = m_act[i];
      r.x[i*XW +: XW] = XW'(m_x[i] / 16);
      r.y[i*YW +: YW] = YW'(m_y[i] / 16);
    end
    return r;
  endfunction

  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      if (m_act[i]) begin
        m_x[i] = (((m_x[i] + m_vx[i]) % LX) + LX) % LX;
        m_y[i] = (((m_y[i] + m_vy[i]) % LY) + LY) % LY;
      end
    end
  endtask

  task automatic tick();
    @(posedge move_clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input int slot, input int x, input int y,
                       input int vx, input int vy);
    cmd_op    = op;
    cmd_slot  = slot[2:0];
    cmd_x     = x[XW-1:0];
    cmd_y     = y[YW-1:0];
    cmd_vx    = vx[VW-1:0];
    cmd_vy    = vy[VW-1:0];
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    case (op)
      OP_SPAWN: begin
        m_act[slot] = 1'b1;
        m_x[slot]   = ((x > 319) ? 319 : x) * 16;
        m_y[slot]   = ((y > 239) ? 239 : y) * 16;
        m_vx[slot]  = vx;
        m_vy[slot]  = vy;
      end
      OP_KILL: m_act[slot] = 1'b0;
      OP_SETV: begin
        m_vx[slot] = vx;
        m_vy[slot] = vy;
      end
      default: ;
    endcase
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
    chk_val({tag, "_drained"}, sb.size(), 0);
  endtask

  task automatic run_sweep(input string tag);
    model_step();
    sb.push_back(snap());
    enable = 1'b1;
    tick();
    start_cyc = cyc;
    enable = 1'b0;
    drain(tag);
    chk_val({tag, "_latency"}, done_cyc - start_cyc, N);
  endtask

  always @(posedge move_clk) cyc <= cyc + 1;

  always @(negedge move_clk) begin
    if (reset_n) begin
      if (w_sweep_done) begin
        done_cyc = cyc;
        chk_val("sweep_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          sb_e = sb.pop_front();
          chk_val("sweep_active", w_ent_active, sb_e.act);
          chk_val("sweep_x", w_ent_x, sb_e.x);
          chk_val("sweep_y", w_ent_y, sb_e.y);
        end
      end
      if (k_exit_event) begin
        k_exits++;
        k_exit_seen = k_exit_slot;
      end
      if (w_exit_event) w_exits++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_vy[i] = 0; m_act[i] = 1'b0;
    end

    // Reset
    reset_n = 1'b0;
    tick();
    @(negedge move_clk);
    chk_val("rst_active", w_ent_active, 0);
    chk_val("rst_x", w_ent_x, 0);
    chk_val("rst_y", w_ent_y, 0);
    chk_val("rst_done", w_sweep_done, 0);
    chk_val("rst_exit", k_exit_event, 0);
    chk_val("rst_ready", w_cmd_ready, 1);
    @(posedge move_clk);
    #1;
    reset_n = 1'b1;

    // Spawn and two sweeps
    issue(OP_SPAWN, 2, 100, 50, 16, -8);
    chk_val("spawn_x2", w_ent_x[2*XW +: XW], 100);
    chk_val("spawn_y2", w_ent_y[2*YW +: YW], 50);
    chk_val("spawn_act2", w_ent_active[2], 1);
    run_sweep("t2a");
    chk_val("t2a_x2", w_ent_x[2*XW +: XW], 101);
    chk_val("t2a_y2", w_ent_y[2*YW +: YW], 49);
    run_sweep("t2b");
    chk_val("t2b_y2", w_ent_y[2*YW +: YW], 49);

    // Edge crossing: wrap vs kill-on-exit
    issue(OP_SPAWN, 0, 319, 0, 16, -16);
    run_sweep("t3");
    chk_val("wrap_x0", w_ent_x[0 +: XW], 0);
    chk_val("wrap_y0", w_ent_y[0 +: YW], 239);
    chk_val("exit_count", k_exits, 1);
    chk_val("exit_slot", k_exit_seen, 0);
    chk_val("exit_active0", k_ent_active[0], 0);
    chk_val("exit_x0_kept", k_ent_x[0 +: XW], 319);
    chk_val("exit_y0_kept", k_ent_y[0 +: YW], 0);
    chk_val("exit_other_alive", k_ent_active[2], 1);

    // Clamped spawn, kill of an inactive slot
    issue(OP_SPAWN, 7, 400, 300, 0, 0);
    chk_val("clamp_x7", w_ent_x[7*XW +: XW], 319);
    chk_val("clamp_y7", w_ent_y[7*YW +: YW], 239);
    issue(OP_KILL, 5, 0, 0, 0, 0);
    sb_e = snap();
    chk_val("kill_idle_act", w_ent_active, sb_e.act);
    chk_val("kill_idle_x", w_ent_x, sb_e.x);
    chk_val("kill_idle_y", w_ent_y, sb_e.y);

    // Set velocity keeps active; exit on the y axis alone in the kill instance
    issue(OP_SETV, 7, 0, 0, -32, 32);
    chk_val("setv_act7", w_ent_active[7], 1);
    run_sweep("t8");
    chk_val("setv_x7", w_ent_x[7*XW +: XW], 317);
    chk_val("setv_y7", w_ent_y[7*YW +: YW], 1);
    chk_val("exit_count7", k_exits, 2);
    chk_val("exit_slot7", k_exit_seen, 7);

    // Command stalled during a sweep, then executed ahead of enable
    model_step();
    sb.push_back(snap());
    enable = 1'b1;
    tick();
    cmd_op    = OP_KILL;
    cmd_slot  = 3'd2;
    cmd_valid = 1'b1;
    busy = 0;
    repeat (8) begin
      @(negedge move_clk);
      if (!w_cmd_ready) busy++;
    end
    chk_val("stall_cycles", busy, 8);
    @(negedge move_clk);
    chk_val("stall_ready_back", w_cmd_ready, 1);
    @(posedge move_clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    m_act[2]  = 1'b0;
    model_step();
    sb.push_back(snap());
    @(negedge move_clk);
    chk_val("stall_kill2", w_ent_active[2], 0);
    chk_val("stall_no_sweep", w_cmd_ready, 1);
    @(posedge move_clk);
    #1;
    enable = 1'b0;
    drain("t5");

    // enable held: back-to-back sweeps with one idle cycle between
    model_step();
    sb.push_back(snap());
    model_step();
    sb.push_back(snap());
    enable = 1'b1;
    tick();
    start_cyc = cyc;
    repeat (8) tick();
    @(negedge move_clk);
    chk_val("b2b_idle_gap", w_cmd_ready, 1);
    @(posedge move_clk);
    #1;
    enable = 1'b0;
    @(negedge move_clk);
    chk_val("b2b_restart", w_cmd_ready, 0);
    drain("t7");
    chk_val("b2b_latency", done_cyc - start_cyc, 2 * N + 1);

    // Reset in the middle of a sweep aborts it
    enable = 1'b1;
    tick();
    enable = 1'b0;
    repeat (3) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge move_clk);
    chk_val("midrst_active", w_ent_active, 0);
    chk_val("midrst_x", w_ent_x, 0);
    chk_val("midrst_y", w_ent_y, 0);
    chk_val("midrst_ready", w_cmd_ready, 1);
    repeat (12) tick();
    chk_val("wrap_no_exit", w_exits, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
